// File: rtl/execute_stage.sv
// execute_stage: ALU execute stage with registered results and optional multi-cycle MUL.
// Define EXECUTE_STAGE_MUL_EN to build the MUL unit; without it MUL retires in one cycle with result 0.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef OPCODE_ALU
`define OPCODE_ALU 7'b0110011
`endif
`ifndef OPCODE_ALU_IMM
`define OPCODE_ALU_IMM 7'b0010011
`endif
`ifndef MUL_FUNCT7
`define MUL_FUNCT7 7'b0000001
`endif

module execute_stage #(
   parameter int WORD_SIZE   = `WORD_SIZE,
   parameter int MUL_LATENCY = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           instruction_type,
   input  logic [WORD_SIZE-1:0] pc,
   input  logic [6:0]           opcode,
   input  logic [6:0]           funct7,
   input  logic [2:0]           funct3,
   input  logic [WORD_SIZE-1:0] s1,
   input  logic [WORD_SIZE-1:0] s2,
   input  logic [WORD_SIZE-1:0] immediate,
   input  logic                 valid,
   input  logic                 stall_in,
   output logic [WORD_SIZE-1:0] result_out,
   output logic [WORD_SIZE-1:0] pc_out,
   output logic [1:0]           instruction_type_out,
   output logic                 valid_out,
   output logic                 stall_out
);
   logic                 is_alu, is_alu_imm, is_mul, is_sub;
   logic [WORD_SIZE-1:0] op_b, alu_result;
   assign is_alu     = opcode == `OPCODE_ALU;
   assign is_alu_imm = opcode == `OPCODE_ALU_IMM;
   assign is_mul     = is_alu && funct7 == `MUL_FUNCT7;
   assign is_sub     = is_alu && funct7 == 7'b0100000;
   assign op_b       = is_alu ? s2 : immediate;
   // Non-ALU opcodes fall through to the address add, as op_b is the immediate there.
   always_comb begin
      alu_result = s1 + op_b;
      if (is_alu || is_alu_imm)
         case (funct3)
            3'b000:  alu_result = is_sub ? s1 - op_b : s1 + op_b;
            3'b001:  alu_result = s1 << op_b[4:0];
            3'b100:  alu_result = s1 ^ op_b;
            3'b101:  alu_result = s1 >> op_b[4:0];
            3'b110:  alu_result = s1 | op_b;
            3'b111:  alu_result = s1 & op_b;
            default: alu_result = s1 + op_b;
         endcase
   end
`ifdef EXECUTE_STAGE_MUL_EN
   localparam int CW = $clog2(MUL_LATENCY);
   typedef enum logic {IDLE, MUL_BUSY} state_t;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [WORD_SIZE-1:0] mul_a, mul_b, mul_pc, product;
   logic [1:0]           mul_type;
   assign product   = mul_a * mul_b;
   // The final busy cycle releases the upstream register so the next op lines up with completion.
   assign stall_out = stall_in | (reset & valid & is_mul & ~(state == MUL_BUSY && cnt == '0));
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state                <= IDLE;
         cnt                  <= '0;
         mul_a                <= '0;
         mul_b                <= '0;
         mul_pc               <= '0;
         mul_type             <= '0;
         result_out           <= '0;
         pc_out               <= '0;
         instruction_type_out <= '0;
         valid_out            <= 1'b0;
      end else if (!stall_in) begin
         if (state == IDLE) begin
            if (valid && is_mul) begin
               mul_a     <= s1;
               mul_b     <= s2;
               mul_pc    <= pc;
               mul_type  <= instruction_type;
               cnt       <= CW'(MUL_LATENCY - 1);
               state     <= MUL_BUSY;
               valid_out <= 1'b0;
            end else begin
               valid_out <= valid;
               if (valid) begin
                  result_out           <= alu_result;
                  pc_out               <= pc;
                  instruction_type_out <= instruction_type;
               end
            end
         end else if (cnt != '0)
            cnt <= cnt - 1'b1;
         else begin
            result_out           <= product;
            pc_out               <= mul_pc;
            instruction_type_out <= mul_type;
            valid_out            <= 1'b1;
            state                <= IDLE;
         end
      end
`else
   logic unused_lat;
   assign unused_lat = MUL_LATENCY >= 2;
   assign stall_out  = stall_in;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         result_out           <= '0;
         pc_out               <= '0;
         instruction_type_out <= '0;
         valid_out            <= 1'b0;
      end else if (!stall_in) begin
         valid_out <= valid;
         if (valid) begin
            result_out           <= is_mul ? '0 : alu_result;
            pc_out               <= pc;
            instruction_type_out <= instruction_type;
         end
      end
`endif
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: random and directed stimulus against a behavioural model of execute_stage.
module tb_execute_stage;
   localparam int LAT = 5;
   localparam logic [6:0] ALU = 7'b0110011, IMM = 7'b0010011, MULF = 7'b0000001;
`ifdef EXECUTE_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0;
   logic [1:0] instruction_type = '0, instruction_type_out;
   logic [31:0] pc = '0, s1 = '0, s2 = '0, immediate = '0, result_out, pc_out;
   logic [6:0] opcode = '0, funct7 = '0;
   logic [2:0] funct3 = '0;
   logic valid = 1'b0, stall_in = 1'b0, valid_out, stall_out;
   int errors = 0, checks = 0;
   logic [31:0] m_result, m_pc, m_a, m_b, m_mpc;
   logic [1:0] m_type, m_mtype;
   logic m_valid, m_busy;
   int m_left;
   logic pin_on = 1'b0, pin_val;
   logic [31:0] pin_res;
   string pin_name = "";

   execute_stage #(.WORD_SIZE(32), .MUL_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .instruction_type(instruction_type), .pc(pc),
      .opcode(opcode), .funct7(funct7), .funct3(funct3), .s1(s1), .s2(s2),
      .immediate(immediate), .valid(valid), .stall_in(stall_in),
      .result_out(result_out), .pc_out(pc_out), .instruction_type_out(instruction_type_out),
      .valid_out(valid_out), .stall_out(stall_out));

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(logic [6:0] op, logic [6:0] f7, logic [2:0] f3,
                                           logic [31:0] a, logic [31:0] b, logic [31:0] imm);
      logic [31:0] y;
      if (op == ALU && f7 == MULF) return 32'd0;
      if (op != ALU && op != IMM) return a + imm;
      y = (op == ALU) ? b : imm;
      case (f3)
         3'd0: return (op == ALU && f7 == 7'b0100000) ? a - y : a + y;
         3'd1: return a << y[4:0];
         3'd4: return a ^ y;
         3'd5: return a >> y[4:0];
         3'd6: return a | y;
         3'd7: return a & y;
         default: return a + y;
      endcase
   endfunction

   function automatic logic exp_stall();
      return stall_in | (reset & MUL_EN & valid & opcode == ALU & funct7 == MULF & ~(m_busy & m_left == 1));
   endfunction

   task automatic model_reset();
      m_result = '0; m_pc = '0; m_type = '0; m_valid = 1'b0; m_busy = 1'b0; m_left = 0;
      m_a = '0; m_b = '0; m_mpc = '0; m_mtype = '0;
   endtask

   // Model: an accepted MUL retires LAT unstalled edges after the edge that accepts it.
   task automatic model_edge();
      if (!reset) begin model_reset(); return; end
      if (stall_in) return;
      if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0; m_result = m_a * m_b; m_pc = m_mpc; m_type = m_mtype; m_valid = 1'b1;
         end
      end else if (valid && MUL_EN && opcode == ALU && funct7 == MULF) begin
         m_busy = 1'b1; m_left = LAT; m_a = s1; m_b = s2; m_mpc = pc; m_mtype = instruction_type;
         m_valid = 1'b0;
      end else begin
         m_valid = valid;
         if (valid) begin
            m_result = ref_alu(opcode, funct7, funct3, s1, s2, immediate);
            m_pc = pc; m_type = instruction_type;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("result_out", result_out, m_result);
      chk("pc_out", pc_out, m_pc);
      chk("instruction_type_out", 32'(instruction_type_out), 32'(m_type));
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("stall_out", 32'(stall_out), 32'(exp_stall()));
      if (pin_on) begin
         chk({pin_name, "_result"}, result_out, pin_res);
         chk({pin_name, "_model"}, m_result, pin_res);
         chk({pin_name, "_valid"}, 32'(valid_out), 32'(pin_val));
      end
   end

   task automatic tick();
      @(posedge clk);
      pin_on = 1'b0;
      model_edge();
      #2;
   endtask

   task automatic pin(string name, logic [31:0] res, logic v);
      pin_name = name; pin_res = res; pin_val = v; pin_on = 1'b1;
   endtask

   task automatic set_in(logic v, logic [6:0] op, logic [6:0] f7, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] b, logic [31:0] imm);
      valid = v; opcode = op; funct7 = f7; funct3 = f3; s1 = a; s2 = b; immediate = imm;
      pc = pc + 32'd4; instruction_type = instruction_type + 2'd1;
   endtask

   function automatic logic [31:0] rnd_word();
      return $urandom_range(1) ? 32'($urandom) : 32'($urandom_range(40));
   endfunction

   initial begin
      model_reset();
      repeat (2) tick();
      reset = 1'b1;
      set_in(1, ALU, 7'd0, 3'd0, 32'd23, 32'd7, 32'd0); tick(); pin("add", 32'd30, 1);
      set_in(1, ALU, 7'b0100000, 3'd0, 32'd7, 32'd23, 32'd0); tick(); pin("sub", 32'hFFFF_FFF0, 1);
      set_in(1, IMM, 7'd0, 3'd7, 32'd212, 32'd0, 32'd879); tick(); pin("and_imm", 32'd68, 1);
      set_in(0, ALU, 7'd0, 3'd0, 32'd1, 32'd1, 32'd0); tick(); pin("bubble", 32'd68, 0);
      set_in(1, ALU, 7'd0, 3'd0, 32'd1, 32'd1, 32'd0); stall_in = 1'b1; tick(); pin("stall_hold", 32'd68, 0);
      stall_in = 1'b0;
      set_in(1, ALU, MULF, 3'd0, 32'd12, 32'd11, 32'd0);
`ifdef EXECUTE_STAGE_MUL_EN
      tick(); s1 = 32'd99;
      repeat (LAT - 1) tick();
      pin("mul_busy", 32'd68, 0);
      tick(); valid = 1'b0; pin("mul", 32'd132, 1);
      tick();
      set_in(1, ALU, MULF, 3'd0, 32'd12, 32'd11, 32'd0);
      repeat (3) tick();
      stall_in = 1'b1; repeat (3) tick(); stall_in = 1'b0;
      repeat (LAT - 3) tick();
      pin("mul_stalled_busy", 32'd132, 0);
      tick(); valid = 1'b0; pin("mul_stalled", 32'd132, 1);
      tick();
      set_in(1, ALU, MULF, 3'd0, 32'd12, 32'd11, 32'd0);
      repeat (2) tick();
      reset = 1'b0; model_reset(); valid = 1'b0; pin("reset_mid_mul", 32'd0, 0);
      tick(); reset = 1'b1;
      repeat (LAT + 2) tick();
      pin("after_abort", 32'd0, 0);
`else
      tick(); valid = 1'b0; pin("mul_disabled", 32'd0, 1);
      tick();
      reset = 1'b0; model_reset(); pin("reset", 32'd0, 0);
      tick(); reset = 1'b1;
`endif
      for (int i = 0; i < 800; i++) begin
         tick();
         if (!reset) reset = 1'b1;
         else if ($urandom_range(63) == 0) begin reset = 1'b0; model_reset(); end
         stall_in = $urandom_range(4) == 0;
         valid = $urandom_range(3) != 0;
         case ($urandom_range(3))
            0: opcode = ALU;
            1: opcode = IMM;
            2: opcode = 7'b0000011;
            default: opcode = 7'($urandom);
         endcase
         case ($urandom_range(3))
            0: funct7 = 7'd0;
            1: funct7 = 7'b0100000;
            2: funct7 = MULF;
            default: funct7 = 7'($urandom);
         endcase
         funct3 = 3'($urandom);
         s1 = rnd_word(); s2 = rnd_word(); immediate = rnd_word();
         pc = $urandom; instruction_type = 2'($urandom);
      end
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
